// File: rtl/key_pkg.sv
// Shared definitions for the pushbutton front-end.
//  - key_state_t : per-key debounce state
//  - DB_CYCLES_DEFAULT / LONG_CYCLES_DEFAULT : 20 ms debounce and 2 s long press at 50 MHz
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int unsigned DB_CYCLES_DEFAULT   = 32'd1_000_000;
    localparam int unsigned LONG_CYCLES_DEFAULT = 32'd100_000_000;

endpackage

// File: rtl/key_debounce_fsm.sv
// One pushbutton channel: 2-FF synchroniser, debounce FSM, debounce and hold
// counters, and registered level / pulse outputs.
// Ports:
//  clk           in  system clock
//  reset         in  synchronous, active-low
//  key_n         in  raw asynchronous key, 0 = pressed
//  key_level_n   out debounced level, 0 = pressed
//  press_pulse   out 1-cycle pulse on an accepted press
//  release_pulse out 1-cycle pulse on an accepted release
//  long_press    out 1-cycle pulse once per hold of LONG_CYCLES pressed cycles
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned DB_W   = $clog2(DB_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    // The edge that leaves IDLE/PRESSED already counts as the first stable
    // sample, so the wait state accepts after DB_CYCLES-1 further samples:
    // DB_CYCLES stable synchronised samples in total.
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 2);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);

    logic              sync1_r;
    logic              sync2_r;
    key_state_t        state_r;
    logic [DB_W-1:0]   db_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              level_r;
    logic              press_r;
    logic              release_r;
    logic              long_r;

    // Synchroniser, debounce FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            state_r    <= IDLE;
            db_cnt_r   <= '0;
            hold_cnt_r <= '0;
            level_r    <= 1'b1;
            press_r    <= 1'b0;
            release_r  <= 1'b0;
            long_r     <= 1'b0;
        end else begin
            sync1_r   <= key_n;
            sync2_r   <= sync1_r;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            long_r    <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (!sync2_r) begin
                        state_r  <= PRESS_WAIT;
                        db_cnt_r <= '0;
                    end else begin
                        db_cnt_r <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (sync2_r) begin
                        state_r  <= IDLE;
                        db_cnt_r <= '0;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r    <= PRESSED;
                        db_cnt_r   <= '0;
                        hold_cnt_r <= '0;
                        level_r    <= 1'b0;
                        press_r    <= 1'b1;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_W'(1);
                    end
                end

                PRESSED: begin
                    if (sync2_r) begin
                        state_r  <= RELEASE_WAIT;
                        db_cnt_r <= '0;
                    end else begin
                        db_cnt_r <= '0;
                    end
                    // Every PRESSED cycle counts, including the one that
                    // leaves for RELEASE_WAIT; saturation gives no auto-repeat.
                    if (hold_cnt_r != HOLD_MAX) begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                        long_r     <= (hold_cnt_r == HOLD_FIRE);
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end

                RELEASE_WAIT: begin
                    if (!sync2_r) begin
                        // Release bounce: back to PRESSED with hold_cnt intact.
                        state_r  <= PRESSED;
                        db_cnt_r <= '0;
                    end else if (db_cnt_r == DB_LAST) begin
                        state_r   <= IDLE;
                        db_cnt_r  <= '0;
                        level_r   <= 1'b1;
                        release_r <= 1'b1;
                    end else begin
                        db_cnt_r <= db_cnt_r + DB_W'(1);
                    end
                end

                default: begin
                    state_r  <= IDLE;
                    db_cnt_r <= '0;
                    level_r  <= 1'b1;
                end
            endcase
        end
    end

    assign key_level_n   = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign long_press    = long_r;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton front-end for the stopwatch/timer: NUM_KEYS independent
// synchronise + debounce channels.
// Ports:
//  clk            in  system clock
//  reset          in  synchronous, active-low
//  key_n          in  [NUM_KEYS] raw async keys, 0 = pressed
//  key_level_n    out [NUM_KEYS] debounced level, 0 = pressed (drives timer start_stop)
//  press_pulse    out [NUM_KEYS] 1-cycle pulse per accepted press
//  release_pulse  out [NUM_KEYS] 1-cycle pulse per accepted release
//  long_press     out [NUM_KEYS] 1-cycle pulse once per long hold
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 2,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEFAULT,
    parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level_n,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_press
);

    if (DB_CYCLES < 2 || LONG_CYCLES <= DB_CYCLES) begin : g_param_error
        $error("key_conditioner: need DB_CYCLES >= 2 and LONG_CYCLES > DB_CYCLES");
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .DB_CYCLES   (DB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_key (
            .clk           (clk),
            .reset         (reset),
            .key_n         (key_n[i]),
            .key_level_n   (key_level_n[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (DB_CYCLES=4, LONG_CYCLES=10, NUM_KEYS=2).
// The reference model tracks, per key, the run length of synchronised samples
// that disagree with the accepted level and the number of pressed cycles.
module tb_key_conditioner;

    localparam int NK   = 2;
    localparam int DB   = 4;
    localparam int LONG = 10;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level_n;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] long_press;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [NK-1:0] m_d1, m_d2, m_level, m_prev;
    logic [NK-1:0] e_press, e_rel, e_long;
    int            m_run  [NK];
    int            m_hold [NK];

    wire [7:0] dut_vec = {key_level_n, press_pulse, release_pulse, long_press};
    wire [7:0] exp_vec = {m_level, e_press, e_rel, e_long};

    key_conditioner #(
        .NUM_KEYS    (NK),
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .key_n         (key_n),
        .key_level_n   (key_level_n),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of one clock edge: a key's accepted level flips once DB
    // consecutive synchronised samples disagree with it; the hold count
    // advances on every cycle the key is accepted pressed and its
    // synchronised input was still low.
    task automatic model_step();
        logic s;
        for (int i = 0; i < NK; i++) begin
            if (!reset) begin
                m_d1[i] = 1'b1; m_d2[i] = 1'b1; m_level[i] = 1'b1; m_prev[i] = 1'b1;
                m_run[i] = 0; m_hold[i] = 0;
                e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0;
            end else begin
                s = m_d2[i];
                m_d2[i] = m_d1[i];
                m_d1[i] = key_n[i];
                e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0;
                if (m_level[i] == 1'b0 && m_prev[i] == 1'b0 && m_hold[i] < LONG) begin
                    m_hold[i]++;
                    if (m_hold[i] == LONG) e_long[i] = 1'b1;
                end
                if (s != m_level[i]) m_run[i]++;
                else m_run[i] = 0;
                if (m_run[i] == DB) begin
                    m_level[i] = s;
                    m_run[i]   = 0;
                    if (s == 1'b0) begin
                        e_press[i] = 1'b1;
                        m_hold[i]  = 0;
                    end else begin
                        e_rel[i] = 1'b1;
                    end
                end
                m_prev[i] = s;
            end
        end
    endtask

    // One clock edge: model updates at the edge, DUT is sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int press_e;
        int rel_seen;
        reset = 1'b0;
        key_n = 2'b00;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (dut_vec !== 8'b1100_0000) begin
                bad++; $display("FAIL reset_hold: got %b want %b", dut_vec, 8'b1100_0000);
            end
        end
        reset = 1'b1;
        press_e = -1;
        rel_seen = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL reset_exit e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
            if (press_pulse == 2'b11 && press_e < 0) press_e = e;
            if (release_pulse != 2'b00) rel_seen = 1;
        end
        total++;
        if (press_e != 5) begin
            bad++; $display("FAIL reset_press_edge: got %0d want 5", press_e);
        end
        total++;
        if (rel_seen != 0) begin
            bad++; $display("FAIL reset_no_release: got %0d want 0", rel_seen);
        end
        key_n = 2'b11;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL reset_settle e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_press();
        int press_e;
        key_n = 2'b10;
        press_e = -1;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL single_model e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
            total++;
            if (key_level_n[1] !== 1'b1 || press_pulse[1] !== 1'b0) begin
                bad++; $display("FAIL single_key1_quiet e=%0d: got lvl=%b prs=%b want 1 0",
                                e, key_level_n[1], press_pulse[1]);
            end
            if (press_pulse[0] && press_e < 0) press_e = e;
        end
        total++;
        if (press_e != 5) begin
            bad++; $display("FAIL single_press_edge: got %0d want 5", press_e);
        end
        key_n = 2'b11;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL single_release e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_glitch();
        int presses;
        int releases;
        int changed;
        for (int len = 3; len <= 4; len++) begin
            presses = 0;
            releases = 0;
            changed = 0;
            for (int e = 0; e < 16; e++) begin
                key_n = (e < len) ? 2'b10 : 2'b11;
                tick();
                total++;
                if (dut_vec !== exp_vec) begin
                    bad++; $display("FAIL glitch%0d_model e=%0d: got %b want %b", len, e, dut_vec, exp_vec);
                end
                if (key_level_n !== 2'b11) changed = 1;
                presses  += int'(press_pulse[0]);
                releases += int'(release_pulse[0]);
            end
            if (len == 3) begin
                total++;
                if (changed != 0 || presses != 0) begin
                    bad++; $display("FAIL glitch3_quiet: got chg=%0d prs=%0d want 0 0", changed, presses);
                end
            end else begin
                total++;
                if (presses != 1 || releases != 1) begin
                    bad++; $display("FAIL glitch4_once: got prs=%0d rel=%0d want 1 1", presses, releases);
                end
            end
        end
    endtask

    task automatic test_long_press();
        int press_e, long_e, long_cnt, rel_e;
        key_n = 2'b10;
        press_e = -1; long_e = -1; long_cnt = 0; rel_e = -1;
        for (int e = 0; e < 70; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL long_model e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
            if (press_pulse[0] && press_e < 0) press_e = e;
            if (long_press[0]) begin
                long_cnt++;
                if (long_e < 0) long_e = e;
            end
        end
        total++;
        if (press_e < 0 || long_e - press_e != LONG) begin
            bad++; $display("FAIL long_delay: got %0d want %0d", long_e - press_e, LONG);
        end
        total++;
        if (long_cnt != 1) begin
            bad++; $display("FAIL long_no_repeat: got %0d want 1", long_cnt);
        end
        key_n = 2'b11;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL long_release e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
            if (release_pulse[0] && rel_e < 0) rel_e = e;
        end
        total++;
        if (rel_e != 5) begin
            bad++; $display("FAIL long_release_edge: got %0d want 5", rel_e);
        end
    endtask

    task automatic test_release_glitch();
        int press_e, long_e, releases;
        press_e = -1; long_e = -1; releases = 0;
        for (int e = 0; e < 30; e++) begin
            key_n = (e == 8 || e == 9) ? 2'b11 : 2'b10;
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL relglitch_model e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
            if (press_pulse[0] && press_e < 0) press_e = e;
            if (long_press[0] && long_e < 0) long_e = e;
            releases += int'(release_pulse[0]);
        end
        total++;
        if (releases != 0 || key_level_n[0] !== 1'b0) begin
            bad++; $display("FAIL relglitch_held: got rel=%0d lvl=%b want 0 0", releases, key_level_n[0]);
        end
        // two RELEASE_WAIT cycles pause the hold count
        total++;
        if (press_e < 0 || long_e - press_e != LONG + 2) begin
            bad++; $display("FAIL relglitch_long: got %0d want %0d", long_e - press_e, LONG + 2);
        end
        key_n = 2'b11;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL relglitch_release e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_simultaneous_reset();
        int press_e;
        for (int pass = 0; pass < 2; pass++) begin
            key_n = 2'b00;
            press_e = -1;
            for (int e = 0; e < 8; e++) begin
                tick();
                total++;
                if (dut_vec !== exp_vec) begin
                    bad++; $display("FAIL simul%0d_model e=%0d: got %b want %b", pass, e, dut_vec, exp_vec);
                end
                if (press_pulse == 2'b11 && press_e < 0) press_e = e;
            end
            total++;
            if (press_e != 5) begin
                bad++; $display("FAIL simul%0d_press_edge: got %0d want 5", pass, press_e);
            end
            if (pass == 0) begin
                reset = 1'b0;
                tick();
                total++;
                if (dut_vec !== 8'b1100_0000) begin
                    bad++; $display("FAIL midhold_reset: got %b want %b", dut_vec, 8'b1100_0000);
                end
                reset = 1'b1;
            end
        end
        key_n = 2'b11;
        for (int e = 0; e < 10; e++) begin
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL simul_settle e=%0d: got %b want %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        int left [NK];
        int pulses;
        for (int i = 0; i < NK; i++) left[i] = 1;
        pulses = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NK; i++) begin
                left[i]--;
                if (left[i] <= 0) begin
                    key_n[i] = ~key_n[i];
                    left[i]  = int'($urandom_range(1, 18));
                end
            end
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick();
            total++;
            if (dut_vec !== exp_vec) begin
                bad++; $display("FAIL random c=%0d: got %b want %b", c, dut_vec, exp_vec);
            end
            if (press_pulse != 2'b00) pulses++;
        end
        reset = 1'b1;
        total++;
        if (pulses == 0) begin
            bad++; $display("FAIL random_activity: got %0d presses want >0", pulses);
        end
    endtask

    initial begin
        reset = 1'b0;
        key_n = 2'b11;
        test_reset();
        test_single_press();
        test_glitch();
        test_long_press();
        test_release_glitch();
        test_simultaneous_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
